// File: rtl/counter8_ctrl.sv
// counter8_ctrl: start/stop 8-bit up/down counter stepped by a synchronized 1 Hz tick, with debounced buttons.
// Latency: count updates on the 3rd clk edge after tick_in rises; a press acts 2 sync + DB_CYCLES + 1 edges after the button settles.
// Backpressure: none; every step and press pulse is consumed in the cycle it appears.
// Optional: define SEG7_DISPLAY_EN to add the multiplexed active-low an[3:0]/seg[6:0] hex display outputs.
module counter8_ctrl #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       up_dn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       tc,
  output logic       running
`ifdef SEG7_DISPLAY_EN
  ,
  output logic [3:0] an,
  output logic [6:0] seg
`endif
);

  localparam int              DB_W    = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

  state_t          state;
  logic            tick_s1, tick_s2, tick_d;
  logic [1:0]      step_guard;
  logic            step;
  logic [1:0]      btn_raw;
  logic [1:0]      btn_s1, btn_s2;
  logic [1:0]      db_lvl, db_prev;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;
  logic            start_press, stop_press;

  // Bit 0 is start, bit 1 is stop throughout the button path.
  assign btn_raw = {btn_stop, btn_start};

  // Two-flop synchronizer and edge register for the tick, plus a guard that
  // holds off steps for 3 cycles after reset so a tick already high is ignored.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      tick_s1    <= 1'b0;
      tick_s2    <= 1'b0;
      tick_d     <= 1'b0;
      step_guard <= 2'd0;
    end else begin
      tick_s1 <= tick_in;
      tick_s2 <= tick_s1;
      tick_d  <= tick_s2;
      if (step_guard != 2'd3)
        step_guard <= step_guard + 2'd1;
    end
  end

  assign step = tick_s2 & ~tick_d & (step_guard == 2'd3);

  // Two-flop synchronizers for both buttons.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      btn_s1 <= 2'b00;
      btn_s2 <= 2'b00;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: the accepted level flips only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      db_lvl <= 2'b00;
      for (int i = 0; i < 2; i++)
        db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Delayed debounced level for press (rising edge) detection.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)
      db_prev <= 2'b00;
    else
      db_prev <= db_lvl;
  end

  assign press       = db_lvl & ~db_prev;
  assign start_press = press[0];
  assign stop_press  = press[1];

  // Run/stop FSM; stop wins when both presses land in the same cycle.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state   <= STOPPED;
      running <= 1'b0;
    end else if (stop_press) begin
      state   <= STOPPED;
      running <= 1'b0;
    end else if (start_press) begin
      state   <= RUNNING;
      running <= 1'b1;
    end
  end

  // Count register: load beats a coincident step; tc marks the cycle holding a wrapped value.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      count <= 8'h00;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tc    <= 1'b0;
    end else if (step && (state == RUNNING)) begin
      if (up_dn) begin
        count <= count + 8'd1;
        tc    <= (count == 8'hFF);
      end else begin
        count <= count - 8'd1;
        tc    <= (count == 8'h00);
      end
    end else begin
      tc <= 1'b0;
    end
  end

`ifdef SEG7_DISPLAY_EN
  logic [16:0] refresh_cnt;
  logic        digit_sel;
  logic [3:0]  nibble;

  // Refresh timer: flip the active digit every 2^17 cycles, low nibble first.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      refresh_cnt <= 17'd0;
      digit_sel   <= 1'b0;
    end else begin
      refresh_cnt <= refresh_cnt + 17'd1;
      if (&refresh_cnt)
        digit_sel <= ~digit_sel;
    end
  end

  assign nibble = digit_sel ? count[7:4] : count[3:0];
  assign an     = digit_sel ? 4'b1101 : 4'b1110;

  // Hex to active-low segments, bit order gfedcba.
  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
`endif

endmodule

// File: tb/tb_counter8_ctrl.sv
// tb_counter8_ctrl: self-checking bench for counter8_ctrl with DB_CYCLES = 4.
// Drives inputs 1 ns after each rising edge and samples outputs at the same point.
// Expected values come from a small arithmetic model of count/running.
`timescale 1ns/1ps
module tb_counter8_ctrl;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       tick_in    = 1'b0;
  logic       btn_start  = 1'b0;
  logic       btn_stop   = 1'b0;
  logic       up_dn      = 1'b1;
  logic       load       = 1'b0;
  logic [7:0] load_val   = 8'h00;
  logic [7:0] count;
  logic       tc;
  logic       running;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] m_count   = 8'h00;
  logic       m_running = 1'b0;

  always #5 clk_100MHz = ~clk_100MHz;

  counter8_ctrl #(.DB_CYCLES(4)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .tick_in    (tick_in),
    .btn_start  (btn_start),
    .btn_stop   (btn_stop),
    .up_dn      (up_dn),
    .load       (load),
    .load_val   (load_val),
    .count      (count),
    .tc         (tc),
    .running    (running)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  // Hold the given buttons long enough to debounce, then release and settle.
  task automatic press(input logic s, input logic p);
    btn_start = s;
    btn_stop  = p;
    cyc(10);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    cyc(10);
  endtask

  // One tick period; reports how many sampled cycles showed tc high.
  task automatic pulse_tick(output int tc_seen);
    tc_seen = 0;
    tick_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      if (tc === 1'b1) tc_seen++;
    end
    tick_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      if (tc === 1'b1) tc_seen++;
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    tick_in = 1'b1;
    cyc(2);
    n_tests++; if (count !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", count); end
    n_tests++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", tc); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
    reset = 1'b0;
    cyc(8);
    n_tests++; if (count !== 8'h00) begin n_fail++; $display("FAIL release_tick_high_count: got %h want 00", count); end
    tick_in = 1'b0;
    cyc(3);
    m_count   = 8'h00;
    m_running = 1'b0;
  endtask

  task automatic test_start_count;
    up_dn = 1'b1;
    press(1'b1, 1'b0);
    m_running = 1'b1;
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %b want 1", running); end
    for (int k = 0; k < 3; k++) begin
      tick_in = 1'b1;
      cyc(2);
      n_tests++; if (count !== m_count) begin n_fail++; $display("FAIL step_early_%0d: got %h want %h", k, count, m_count); end
      cyc(1);
      m_count = 8'((int'(m_count) + 1) % 256);
      n_tests++; if (count !== m_count) begin n_fail++; $display("FAIL step_third_edge_%0d: got %h want %h", k, count, m_count); end
      tick_in = 1'b0;
      cyc(4);
    end
    n_tests++; if (count !== 8'd3) begin n_fail++; $display("FAIL start_count_total: got %h want 03", count); end
  endtask

  task automatic test_wrap_up;
    load_val = 8'hFE;
    load     = 1'b1;
    cyc(1);
    load = 1'b0;
    m_count = 8'hFE;
    n_tests++; if (count !== 8'hFE) begin n_fail++; $display("FAIL load_fe: got %h want fe", count); end
    up_dn   = 1'b1;
    tick_in = 1'b1;
    cyc(3);
    n_tests++; if (count !== 8'hFF || tc !== 1'b0) begin n_fail++; $display("FAIL up_to_ff: got count %h tc %b want ff 0", count, tc); end
    tick_in = 1'b0;
    cyc(4);
    tick_in = 1'b1;
    cyc(3);
    n_tests++; if (count !== 8'h00 || tc !== 1'b1) begin n_fail++; $display("FAIL up_wrap: got count %h tc %b want 00 1", count, tc); end
    cyc(1);
    n_tests++; if (tc !== 1'b0) begin n_fail++; $display("FAIL up_wrap_tc_width: got %b want 0", tc); end
    tick_in = 1'b0;
    cyc(4);
    m_count = 8'h00;
  endtask

  task automatic test_wrap_down_load;
    logic [7:0] v;
    up_dn   = 1'b0;
    tick_in = 1'b1;
    cyc(3);
    n_tests++; if (count !== 8'hFF || tc !== 1'b1) begin n_fail++; $display("FAIL down_wrap: got count %h tc %b want ff 1", count, tc); end
    cyc(1);
    n_tests++; if (tc !== 1'b0) begin n_fail++; $display("FAIL down_wrap_tc_width: got %b want 0", tc); end
    tick_in = 1'b0;
    cyc(4);
    v       = 8'($urandom_range(1, 254));
    tick_in = 1'b1;
    cyc(2);
    load     = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
    n_tests++; if (count !== v || tc !== 1'b0) begin n_fail++; $display("FAIL load_over_step: got count %h tc %b want %h 0", count, tc, v); end
    cyc(1);
    n_tests++; if (tc !== 1'b0) begin n_fail++; $display("FAIL load_over_step_tc: got %b want 0", tc); end
    tick_in = 1'b0;
    cyc(4);
    n_tests++; if (count !== v) begin n_fail++; $display("FAIL load_hold: got %h want %h", count, v); end
    m_count = v;
  endtask

  task automatic test_bounce;
    int   trans;
    logic prev;
    press(1'b0, 1'b1);
    m_running = 1'b0;
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL bounce_pre_stop: got %b want 0", running); end
    trans = 0;
    prev  = running;
    for (int g = 0; g < 4; g++) begin
      btn_start = 1'b1;
      for (int k = 0; k < 3; k++) begin cyc(1); if (running !== prev) trans++; prev = running; end
      btn_start = 1'b0;
      for (int k = 0; k < 3; k++) begin cyc(1); if (running !== prev) trans++; prev = running; end
    end
    n_tests++; if (trans !== 0) begin n_fail++; $display("FAIL bounce_glitch_transitions: got %0d want 0", trans); end
    btn_start = 1'b1;
    for (int k = 0; k < 12; k++) begin cyc(1); if (running !== prev) trans++; prev = running; end
    btn_start = 1'b0;
    for (int k = 0; k < 10; k++) begin cyc(1); if (running !== prev) trans++; prev = running; end
    m_running = 1'b1;
    n_tests++; if (trans !== 1 || running !== 1'b1) begin n_fail++; $display("FAIL bounce_single_start: got %0d transitions running %b want 1 1", trans, running); end
  endtask

  task automatic test_coincident;
    int seen;
    int tc_total;
    press(1'b1, 1'b1);
    m_running = 1'b0;
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL coincident_from_running: got %b want 0", running); end
    press(1'b1, 1'b1);
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL coincident_from_stopped: got %b want 0", running); end
    tc_total = 0;
    for (int k = 0; k < 3; k++) begin
      up_dn = 1'($urandom_range(0, 1));
      pulse_tick(seen);
      tc_total += seen;
    end
    n_tests++; if (count !== m_count || tc_total !== 0) begin n_fail++; $display("FAIL stopped_ticks: got count %h tc %0d want %h 0", count, tc_total, m_count); end
  endtask

  task automatic test_reset_midrun;
    press(1'b1, 1'b0);
    up_dn   = 1'b1;
    tick_in = 1'b1;
    cyc(1);
    #2 reset = 1'b1;
    #1;
    n_tests++; if (count !== 8'h00 || running !== 1'b0) begin n_fail++; $display("FAIL async_reset: got count %h running %b want 00 0", count, running); end
    cyc(2);
    reset = 1'b0;
    cyc(10);
    m_count   = 8'h00;
    m_running = 1'b0;
    press(1'b1, 1'b0);
    m_running = 1'b1;
    n_tests++; if (count !== 8'h00 || running !== 1'b1) begin n_fail++; $display("FAIL post_reset_no_step: got count %h running %b want 00 1", count, running); end
    tick_in = 1'b0;
    cyc(4);
    tick_in = 1'b1;
    cyc(3);
    m_count = 8'h01;
    n_tests++; if (count !== m_count) begin n_fail++; $display("FAIL post_reset_first_step: got %h want %h", count, m_count); end
    tick_in = 1'b0;
    cyc(4);
  endtask

  task automatic test_random;
    int seen;
    int nxt;
    int exp_tc;
    for (int i = 0; i < 40; i++) begin
      int op = $urandom_range(0, 5);
      exp_tc = 0;
      if (op <= 2) begin
        up_dn = 1'($urandom_range(0, 1));
        pulse_tick(seen);
        if (m_running) begin
          nxt     = int'(m_count) + (up_dn ? 1 : -1);
          exp_tc  = (nxt < 0 || nxt > 255) ? 1 : 0;
          m_count = 8'((nxt + 256) % 256);
        end
        n_tests++; if (seen !== exp_tc) begin n_fail++; $display("FAIL rand_tc_%0d: got %0d pulses want %0d", i, seen, exp_tc); end
      end else if (op == 3) begin
        case ($urandom_range(0, 2))
          0:       load_val = 8'($urandom_range(250, 255));
          1:       load_val = 8'($urandom_range(0, 5));
          default: load_val = 8'($urandom_range(0, 255));
        endcase
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(1);
        m_count = load_val;
      end else if (op == 4) begin
        press(1'b1, 1'b0);
        m_running = 1'b1;
      end else begin
        press(1'b0, 1'b1);
        m_running = 1'b0;
      end
      n_tests++; if (count !== m_count || running !== m_running) begin n_fail++; $display("FAIL rand_state_%0d: got count %h running %b want %h %b", i, count, running, m_count, m_running); end
    end
  endtask

  initial begin
    test_reset;
    test_start_count;
    test_wrap_up;
    test_wrap_down_load;
    test_bounce;
    test_coincident;
    test_reset_midrun;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
